// File: rtl/execute_pkg.sv
// riscv_structures: shared types and constants for the RV32 execute stage
// Provides XLEN, ALU/muldiv op enums, the muldiv FSM state enum, and the ID->EX / EX->MEM payloads.
package riscv_structures;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB, ALU_AUIPC
  } alu_op_e;
  typedef enum logic [2:0] {MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU} muldiv_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    alu_op_e         alu_op;
    logic            is_muldiv;
    muldiv_op_e      muldiv_op;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_to_ex_s;
  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [4:0]      rd;
  } ex_to_mem_s;
endpackage

// File: rtl/execute_if.sv
// execute_if: decode/execute/memory bundle
// Signals: id_to_ex (decode -> execute), ex_to_mem (execute -> memory), stall (execute -> decode).
// master = decode/memory side, slave = execute.
interface execute_if;
  import riscv_structures::*;
  id_to_ex_s  id_to_ex;
  ex_to_mem_s ex_to_mem;
  logic       stall;
  modport master (output id_to_ex, input ex_to_mem, input stall);
  modport slave (input id_to_ex, output ex_to_mem, output stall);
endinterface

// File: rtl/execute_muldiv_unit.sv
// muldiv_unit: iterative 32-step shift-add multiplier and restoring divider
// Ports: clk, rst (sync, active-high), start/op/a/b (accepted in IDLE), busy (BUSY), done (DONE), result (valid in DONE).
module muldiv_unit
  import riscv_structures::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  muldiv_op_e      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  md_state_e       r_state, w_next;
  muldiv_op_e      r_op;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_x, r_y, r_acc;
  logic            r_qneg, r_rneg;
  logic            w_signed, w_sa, w_sb, w_mul;
  logic [XLEN:0]   w_sh, w_diff;
  logic [XLEN-1:0] w_q, w_r;
  assign w_signed = op == MD_DIV || op == MD_REM;
  assign w_sa     = w_signed & a[XLEN-1];
  assign w_sb     = w_signed & b[XLEN-1];
  assign w_mul    = r_op == MD_MUL;
  // r_x holds the dividend bits still to shift in, and collects quotient bits in their place
  assign w_sh     = {r_acc, r_x[XLEN-1]};
  assign w_diff   = w_sh - {1'b0, r_y};
  // A zero divisor keeps the all-ones quotient unsigned so both signednesses agree
  assign w_q      = r_qneg ? -r_x : r_x;
  assign w_r      = r_rneg ? -r_acc : r_acc;
  assign busy     = r_state == BUSY;
  assign done     = r_state == DONE;
  assign result   = w_mul ? r_acc : (r_op == MD_DIV || r_op == MD_DIVU) ? w_q : w_r;
  always_comb begin
    w_next = r_state == IDLE ? (start ? BUSY : IDLE) :
             r_state == BUSY ? (r_cnt == 5'd0 ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 5'd0;
    end else if (r_state == IDLE && start) begin
      r_op   <= op;
      r_x    <= op == MD_MUL ? a : (w_sa ? -a : a);
      r_y    <= op == MD_MUL ? b : (w_sb ? -b : b);
      r_acc  <= '0;
      r_qneg <= (w_sa ^ w_sb) & |b;
      r_rneg <= w_sa;
      r_cnt  <= 5'd31;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt - 5'd1;
      if (w_mul) begin
        r_acc <= r_acc + (r_y[0] ? r_x : '0);
        r_x   <= r_x << 1;
        r_y   <= r_y >> 1;
      end else begin
        r_acc <= w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
        r_x   <= {r_x[XLEN-2:0], ~w_diff[XLEN]};
      end
    end
  end
endmodule

// File: rtl/execute.sv
// execute: RV32 execute stage with single-cycle ALU, iterative muldiv and registered EX->MEM output
// Ports: clk, rst (sync, active-high), bus (execute_if.slave: id_to_ex in, ex_to_mem out, stall out).
module execute
  import riscv_structures::*;
(
  input  logic      clk,
  input  logic      rst,
  execute_if.slave  bus
);
  id_to_ex_s       w_id;
  ex_to_mem_s      r_ex_to_mem;
  logic [XLEN-1:0] w_b, w_alu, w_md_result;
  logic            w_md_busy, w_md_done, w_md;
  assign w_id = bus.id_to_ex;
  assign w_b  = w_id.use_imm ? w_id.imm : w_id.rs2_val;
  assign w_md = w_id.valid & w_id.is_muldiv;
  // Stall covers the accepting cycle and every BUSY cycle; it drops in DONE
  assign bus.stall     = ~rst & w_md & ~w_md_done;
  assign bus.ex_to_mem = r_ex_to_mem;
  muldiv_unit u_muldiv (
    .clk(clk), .rst(rst), .start(w_md), .op(w_id.muldiv_op),
    .a(w_id.rs1_val), .b(w_id.rs2_val),
    .busy(w_md_busy), .done(w_md_done), .result(w_md_result)
  );
  always_comb begin
    w_alu = '0;
    case (w_id.alu_op)
      ALU_ADD:   w_alu = w_id.rs1_val + w_b;
      ALU_SUB:   w_alu = w_id.rs1_val - w_b;
      ALU_AND:   w_alu = w_id.rs1_val & w_b;
      ALU_OR:    w_alu = w_id.rs1_val | w_b;
      ALU_XOR:   w_alu = w_id.rs1_val ^ w_b;
      ALU_SLL:   w_alu = w_id.rs1_val << w_b[4:0];
      ALU_SRL:   w_alu = w_id.rs1_val >> w_b[4:0];
      ALU_SRA:   w_alu = XLEN'($signed(w_id.rs1_val) >>> w_b[4:0]);
      ALU_SLT:   w_alu = {31'd0, $signed(w_id.rs1_val) < $signed(w_b)};
      ALU_SLTU:  w_alu = {31'd0, w_id.rs1_val < w_b};
      ALU_PASSB: w_alu = w_b;
      ALU_AUIPC: w_alu = w_id.pc + w_id.imm;
      default:   w_alu = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || !w_id.valid || (w_id.is_muldiv && !w_md_done))
      r_ex_to_mem <= '0;
    else
      r_ex_to_mem <= '{
        alu_result: w_id.is_muldiv ? w_md_result : w_alu,
        write_data: w_id.rs2_val,
        mem_read:   w_id.mem_read,
        mem_write:  w_id.mem_write,
        reg_write:  w_id.reg_write,
        rd:         w_id.rd
      };
  end
  logic w_unused;
  assign w_unused = w_md_busy;
endmodule

// File: tb/tb_execute.sv
// tb_execute: self-checking bench for the execute stage
module tb_execute;
  import riscv_structures::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic prev_st = 1'b0;
  id_to_ex_s prev_id = '0;
  execute_if bus();
  execute dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (prev_st) begin
      n_tests++;
      assert (bus.id_to_ex === prev_id) else begin
        n_fail++;
        $error("FAIL id_stable got=%h exp=%h", bus.id_to_ex, prev_id);
      end
    end
    prev_st = bus.stall;
    prev_id = bus.id_to_ex;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] alu_ref(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                          logic [31:0] pc, logic [31:0] imm);
    int sa = a;
    int sb = b;
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << (b % 32);
      ALU_SRL:   return a >> (b % 32);
      ALU_SRA:   return 32'(sa >>> (b % 32));
      ALU_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASSB: return b;
      ALU_AUIPC: return pc + imm;
      default:   return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] md_ref(muldiv_op_e op, logic [31:0] a, logic [31:0] b);
    int sa = a;
    int sb = b;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_MUL:  return a * b;
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REMU: return (b == 0) ? a : a % b;
      MD_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      MD_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return 32'd0;
    endcase
  endfunction
  task automatic set_alu(input alu_op_e op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic ui, input logic [31:0] pc,
                         input logic [4:0] rd);
    bus.id_to_ex           = '0;
    bus.id_to_ex.valid     = 1'b1;
    bus.id_to_ex.alu_op    = op;
    bus.id_to_ex.rs1_val   = rs1;
    bus.id_to_ex.rs2_val   = rs2;
    bus.id_to_ex.imm       = imm;
    bus.id_to_ex.use_imm   = ui;
    bus.id_to_ex.pc        = pc;
    bus.id_to_ex.rd        = rd;
    bus.id_to_ex.reg_write = 1'b1;
  endtask
  task automatic run_alu(input string tag, input alu_op_e op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic ui,
                         input logic [31:0] pc, input logic [31:0] exp);
    set_alu(op, rs1, rs2, imm, ui, pc, 5'd7);
    #1;
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    tick();
    check(tag, bus.ex_to_mem.alu_result, exp);
  endtask
  task automatic run_md(input string tag, input muldiv_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int cnt = 0;
    logic bad = 1'b0;
    bus.id_to_ex           = '0;
    bus.id_to_ex.valid     = 1'b1;
    bus.id_to_ex.is_muldiv = 1'b1;
    bus.id_to_ex.muldiv_op = op;
    bus.id_to_ex.rs1_val   = a;
    bus.id_to_ex.rs2_val   = b;
    bus.id_to_ex.rd        = 5'd9;
    bus.id_to_ex.reg_write = 1'b1;
    #1;
    while (bus.stall && cnt < 100) begin
      if (cnt > 0 && bus.ex_to_mem !== '0) bad = 1'b1;
      cnt++;
      tick();
    end
    if (bus.ex_to_mem !== '0) bad = 1'b1;
    check({tag, "_stallcyc"}, 32'(cnt), 32'd33);
    check({tag, "_bubbles"}, 32'(bad), 32'd0);
    tick();
    check(tag, bus.ex_to_mem.alu_result, exp);
    check({tag, "_ctl"}, {26'd0, bus.ex_to_mem.rd, bus.ex_to_mem.reg_write}, {26'd0, 5'd9, 1'b1});
    bus.id_to_ex.valid = 1'b0;
  endtask
  initial begin
    logic [31:0] ra, rb, ri, rp;
    alu_op_e aop;
    muldiv_op_e mop;
    logic bad;
    bus.id_to_ex = '0;
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    set_alu(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 32'd0, 5'd3);
    #1;
    check("rst_bubble", 32'(bus.ex_to_mem !== '0), 32'd0);
    tick();
    check("add_after_rst", bus.ex_to_mem.alu_result, 32'd12);
    check("add_ctl", {26'd0, bus.ex_to_mem.rd, bus.ex_to_mem.reg_write}, {26'd0, 5'd3, 1'b1});
    check("add_wdata", bus.ex_to_mem.write_data, 32'd7);
    run_alu("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 32'd0, 32'hF800_0000);
    run_alu("sltu", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 32'd1);
    run_alu("slt", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 32'd0);
    run_alu("sub", ALU_SUB, 32'd0, 32'd1, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFF);
    run_alu("auipc", ALU_AUIPC, 32'd0, 32'd0, 32'h2000, 1'b1, 32'h100, 32'h2100);
    run_alu("passb_imm", ALU_PASSB, 32'd1, 32'd2, 32'hABCD_E000, 1'b1, 32'd0, 32'hABCD_E000);
    run_alu("sll_shamt", ALU_SLL, 32'd1, 32'h0000_0025, 32'd0, 1'b0, 32'd0, 32'd32);
    for (int i = 0; i < 16; i++) begin
      aop = alu_op_e'($urandom_range(0, 11));
      ra = $urandom; rb = $urandom; ri = $urandom; rp = $urandom;
      bad = 1'($urandom_range(0, 1));
      run_alu("alu_rand", aop, ra, rb, ri, bad, rp, alu_ref(aop, ra, bad ? ri : rb, rp, ri));
    end
    run_md("mul", MD_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_md("divu_zero", MD_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_md("div_zero_neg", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_md("rem_zero_neg", MD_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    run_md("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      mop = muldiv_op_e'($urandom_range(0, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
      run_md("md_rand", mop, ra, rb, md_ref(mop, ra, rb));
    end
    run_md("b2b_mul", MD_MUL, 32'd6, 32'd7, 32'd42);
    set_alu(ALU_ADD, 32'd100, 32'd1, 32'd0, 1'b0, 32'd0, 5'd4);
    #1;
    check("b2b_stall", 32'(bus.stall), 32'd0);
    tick();
    check("b2b_add", bus.ex_to_mem.alu_result, 32'd101);
    bus.id_to_ex           = '0;
    bus.id_to_ex.valid     = 1'b1;
    bus.id_to_ex.is_muldiv = 1'b1;
    bus.id_to_ex.muldiv_op = MD_DIVU;
    bus.id_to_ex.rs1_val   = 32'd100;
    bus.id_to_ex.rs2_val   = 32'd3;
    bus.id_to_ex.rd        = 5'd11;
    bus.id_to_ex.reg_write = 1'b1;
    #1;
    check("abort_start_stall", 32'(bus.stall), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    check("abort_rst_stall", 32'(bus.stall), 32'd0);
    tick();
    rst = 1'b0;
    bus.id_to_ex.valid = 1'b0;
    #1;
    check("abort_stall", 32'(bus.stall), 32'd0);
    check("abort_bubble", 32'(bus.ex_to_mem !== '0), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ex_to_mem !== '0 || bus.stall) bad = 1'b1;
    end
    check("abort_no_result", 32'(bad), 32'd0);
    run_alu("post_abort_add", ALU_ADD, 32'd20, 32'd22, 32'd0, 1'b0, 32'd0, 32'd42);
    bus.id_to_ex.valid = 1'b0;
    tick();
    check("idle_bubble", 32'(bus.ex_to_mem !== '0), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
